// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction fetch/issue slice:
// opcodes, IR field positions and fetch-state encoding.
`default_nettype none

package isa_pkg;

   localparam logic [4:0] OP_MOVSGPR = 5'd0;
   localparam logic [4:0] OP_MOV     = 5'd1;
   localparam logic [4:0] OP_ADD     = 5'd2;
   localparam logic [4:0] OP_SUB     = 5'd3;
   localparam logic [4:0] OP_MUL     = 5'd4;
   localparam logic [4:0] OP_HALT    = 5'b11111;

   localparam int OP_MSB       = 31;
   localparam int OP_LSB       = 27;
   localparam int RDST_MSB     = 26;
   localparam int RDST_LSB     = 22;
   localparam int RSRC1_MSB    = 21;
   localparam int RSRC1_LSB    = 17;
   localparam int IMM_MODE_BIT = 16;
   localparam int RSRC2_MSB    = 15;
   localparam int RSRC2_LSB    = 11;
   localparam int IMM_MSB      = 15;
   localparam int IMM_LSB      = 0;

   typedef logic [1:0] fetch_state_t;
   localparam fetch_state_t ST_IDLE   = 2'd0;
   localparam fetch_state_t ST_RUN    = 2'd1;
   localparam fetch_state_t ST_DRAIN  = 2'd2;
   localparam fetch_state_t ST_HALTED = 2'd3;

   function automatic logic [4:0] ir_op(input logic [31:0] word);
      return word[OP_MSB:OP_LSB];
   endfunction

   // Executable opcodes occupy the contiguous range MOVSGPR..MUL.
   function automatic logic op_supported(input logic [4:0] op);
      return (op <= OP_MUL);
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_issue_if.sv
// Instruction-memory read port plus IR valid/ready issue channel.
`default_nettype none

interface instr_fetch_issue_if #(
   parameter int ADDR_W = 8
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              ir_valid;
   logic              ir_ready;
   logic [31:0]       ir_out;
   logic [ADDR_W-1:0] pc_out;

   modport master (
      output imem_req, imem_addr, ir_valid, ir_out, pc_out,
      input  imem_rdata, ir_ready
   );

   modport slave (
      input  imem_req, imem_addr, ir_valid, ir_out, pc_out,
      output imem_rdata, ir_ready
   );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_issue_fifo.sv
// Prefetch queue: synchronous FIFO with clear, occupancy count and head view.
`default_nettype none

module ifq_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 40
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     clear_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         head_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W:0]   CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W:0]   count_q;

   // Storage is reset so the head view reads zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + PTR_ONE;
         end
         if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_issue.sv
// Instruction fetch/issue: fetches from synchronous imem into a prefetch
// queue and issues {pc, word} over a valid/ready IR channel.
`default_nettype none

module instr_fetch_issue
   import isa_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    start_addr,
   input  logic                 flush,
   input  logic [ADDR_W-1:0]    flush_addr,
   instr_fetch_issue_if.master  bus,
   output logic                 busy,
   output logic                 halted,
   output logic                 illegal
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] rsp_pc_q;
   logic              inflight_q;
   logic              drop_q, drop_d;
   logic              illegal_q, illegal_d;

   logic [CNT_W-1:0]      count;
   logic [CNT_W:0]        credit_used;
   logic [ADDR_W+31:0]    head;
   logic [4:0]            rsp_op;
   logic                  req, rsp_ok, rsp_push, rsp_stop, pop, flush_act;

   assign flush_act   = flush && (state_q != ST_IDLE);
   assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
   // Credit counts the in-flight word but deliberately ignores a same-cycle pop.
   assign req         = (state_q == ST_RUN) && (credit_used < DEPTH_C) && !flush;

   assign rsp_op   = ir_op(bus.imem_rdata);
   assign rsp_ok   = inflight_q && !drop_q && (state_q == ST_RUN) && !flush;
   assign rsp_push = rsp_ok && op_supported(rsp_op);
   assign rsp_stop = rsp_ok && !op_supported(rsp_op);
   assign pop      = bus.ir_valid && bus.ir_ready;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      drop_d    = 1'b0;
      illegal_d = illegal_q;
      if (req) pc_d = pc_q + PC_ONE;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               pc_d    = start_addr;
            end
         end
         ST_RUN: begin
            // A stop word kills the request already issued behind it.
            if (rsp_stop) begin
               state_d = ST_DRAIN;
               drop_d  = 1'b1;
               if (rsp_op != OP_HALT) illegal_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (count == '0) state_d = ST_HALTED;
         end
         default: state_d = state_q;
      endcase
      if (flush_act) begin
         state_d = ST_RUN;
         pc_d    = flush_addr;
         drop_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         rsp_pc_q   <= '0;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= req;
         drop_q     <= drop_d;
         illegal_q  <= illegal_d;
         if (req) rsp_pc_q <= pc_q;
      end
   end

   ifq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ADDR_W + 32)
   ) u_ifq (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (rsp_push),
      .pop_i   (pop),
      .clear_i (flush_act),
      .data_i  ({rsp_pc_q, bus.imem_rdata}),
      .head_o  (head),
      .count_o (count)
   );

   assign bus.imem_req  = req;
   assign bus.imem_addr = pc_q;
   assign bus.ir_valid  = (count != '0);
   assign bus.ir_out    = head[31:0];
   assign bus.pc_out    = head[ADDR_W+31:32];
   assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign halted        = (state_q == ST_HALTED);
   assign illegal       = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_issue.sv
// Directed scoreboard bench for instr_fetch_issue.
`timescale 1ns/1ps
`default_nettype none

module tb_instr_fetch_issue;
   import isa_pkg::*;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [7:0]  start_addr = '0;
   logic [7:0]  flush_addr = '0;
   logic        busy, halted, illegal;

   int checks = 0;
   int failures = 0;
   int req_cnt = 0;
   int issued = 0;
   logic [31:0] mem [256];
   logic [39:0] sb [$];
   logic [7:0]  addr_log [$];

   instr_fetch_issue_if #(.ADDR_W(ADDR_W)) bus ();

   instr_fetch_issue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .flush      (flush),
      .flush_addr (flush_addr),
      .bus        (bus),
      .busy       (busy),
      .halted     (halted),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.imem_req) bus.imem_rdata <= mem[bus.imem_addr];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [7:0] a);
      return {op, 3'b101, a, 8'h5A, ~a};
   endfunction

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input logic [7:0] a);
      sb.push_back({a, mem[a]});
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick();
      sb.delete();
      addr_log.delete();
      req_cnt = 0;
   endtask

   task automatic wait_halted(input string tag);
      int n = 0;
      while (!halted && n < 60) begin tick(); n++; end
      check(tag, halted, 1);
   endtask

   // Monitor: log requests, pop/compare every handshake against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && bus.imem_req) begin
         req_cnt++;
         addr_log.push_back(bus.imem_addr);
      end
      if (rst_n && bus.ir_valid && bus.ir_ready) begin
         logic [39:0] exp_item;
         exp_item = (sb.size() != 0) ? sb.pop_front() : 'x;
         issued++;
         check("issue_pc_word", {24'h0, bus.pc_out, bus.ir_out}, {24'h0, exp_item});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] held;
      int n0, n;
      logic [7:0] a;
      logic [7:0] exp_addrs [4];
      exp_addrs[0] = 8'hFE; exp_addrs[1] = 8'hFF; exp_addrs[2] = 8'h00; exp_addrs[3] = 8'h01;
      for (int i = 0; i < 256; i++) mem[i] = mk(OP_HALT, 8'(i));
      bus.ir_ready = 1'b0;

      // Reset state
      tick(2);
      check("rst_outputs", {11'h0, bus.imem_req, bus.imem_addr, bus.ir_valid, bus.ir_out,
                            bus.pc_out, busy, halted, illegal}, 64'h0);
      rst_n = 1'b1;
      tick();

      // Latency and HALT termination
      for (int i = 8'h10; i < 8'h14; i++) begin mem[i] = mk(OP_ADD, 8'(i)); expect_word(8'(i)); end
      mem[8'h15] = mk(OP_ADD, 8'h15);
      bus.ir_ready = 1'b1;
      start_addr = 8'h10; start = 1'b1;
      tick();
      start = 1'b0;
      check("lat_req_t1", {bus.imem_req, bus.imem_addr}, {1'b1, 8'h10});
      tick();
      check("lat_valid_t2", bus.ir_valid, 0);
      tick();
      check("lat_valid_t3", {bus.ir_valid, bus.pc_out}, {1'b1, 8'h10});
      tick();
      check("lat_valid_t4", {bus.ir_valid, bus.pc_out}, {1'b1, 8'h11});
      wait_halted("halt_reached");
      check("halt_sb_empty", sb.size(), 0);
      check("halt_not_busy", {busy, illegal}, 2'b00);

      // Backpressure: ready low for 10 cycles
      do_reset();
      for (int i = 8'h30; i < 8'h36; i++) begin mem[i] = mk(OP_MOV, 8'(i)); expect_word(8'(i)); end
      bus.ir_ready = 1'b0;
      start_addr = 8'h30; start = 1'b1;
      tick();
      start = 1'b0;
      tick(2);
      check("bp_first_head", {bus.ir_valid, bus.pc_out}, {1'b1, 8'h30});
      held = {bus.pc_out, bus.ir_out};
      for (int i = 0; i < 7; i++) begin
         tick();
         check("bp_stable", {bus.pc_out, bus.ir_out}, held);
      end
      check("bp_req_count", req_cnt, 4);
      bus.ir_ready = 1'b1;
      wait_halted("bp_halted");
      check("bp_sb_empty", sb.size(), 0);

      // Asynchronous reset mid-RUN with a non-empty queue
      do_reset();
      for (int i = 8'h50; i < 8'h54; i++) mem[i] = mk(OP_SUB, 8'(i));
      bus.ir_ready = 1'b0;
      start_addr = 8'h50; start = 1'b1;
      tick();
      start = 1'b0;
      tick(4);
      check("rst_mid_pre_valid", {bus.ir_valid, busy}, 2'b11);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_outputs", {11'h0, bus.imem_req, bus.imem_addr, bus.ir_valid, bus.ir_out,
                                bus.pc_out, busy, halted, illegal}, 64'h0);
      tick(2);
      rst_n = 1'b1;
      tick();
      sb.delete(); addr_log.delete(); req_cnt = 0;

      // Address wrap 0xFE -> 0x01
      mem[8'hFE] = mk(OP_MUL, 8'hFE); mem[8'hFF] = mk(OP_MUL, 8'hFF);
      mem[8'h00] = mk(OP_MUL, 8'h00); mem[8'h01] = mk(OP_MUL, 8'h01);
      mem[8'h02] = mk(OP_HALT, 8'h02);
      expect_word(8'hFE); expect_word(8'hFF); expect_word(8'h00); expect_word(8'h01);
      bus.ir_ready = 1'b1;
      start_addr = 8'hFE; start = 1'b1;
      tick();
      start = 1'b0;
      wait_halted("wrap_halted");
      for (int i = 0; i < 4; i++) begin
         a = (i < addr_log.size()) ? addr_log[i] : 8'hxx;
         check("wrap_imem_addr", a, exp_addrs[i]);
      end
      check("wrap_sb_empty", sb.size(), 0);

      // Illegal opcode, then flush restart with sticky illegal
      mem[8'h20] = mk(OP_ADD, 8'h20); mem[8'h21] = mk(OP_ADD, 8'h21);
      mem[8'h22] = mk(5'b01010, 8'h22); mem[8'h23] = mk(OP_ADD, 8'h23);
      expect_word(8'h20); expect_word(8'h21);
      bus.ir_ready = 1'b0;
      flush_addr = 8'h20; flush = 1'b1;
      tick();
      flush = 1'b0;
      n = 0;
      while (!illegal && n < 30) begin tick(); n++; end
      tick();
      check("ill_flag", illegal, 1);
      check("ill_drain_state", {busy, halted}, 2'b10);
      check("ill_head_kept", {bus.ir_valid, bus.pc_out}, {1'b1, 8'h20});
      bus.ir_ready = 1'b1;
      wait_halted("ill_halted");
      check("ill_sb_empty", sb.size(), 0);
      mem[8'h60] = mk(OP_SUB, 8'h60); mem[8'h61] = mk(OP_HALT, 8'h61);
      expect_word(8'h60);
      flush_addr = 8'h60; flush = 1'b1;
      tick();
      flush = 1'b0;
      check("ill_restart_run", {busy, halted, illegal}, 3'b101);
      wait_halted("ill_restart_halted");
      check("ill_sticky", illegal, 1);
      check("ill_restart_sb_empty", sb.size(), 0);

      // Flush concurrent with a response and a pop
      for (int i = 8'h70; i < 8'h80; i++) begin mem[i] = mk(OP_ADD, 8'(i)); expect_word(8'(i)); end
      mem[8'h40] = mk(OP_MUL, 8'h40); mem[8'h41] = mk(OP_HALT, 8'h41);
      bus.ir_ready = 1'b1;
      flush_addr = 8'h70; flush = 1'b1;
      tick();
      flush = 1'b0;
      tick(6);
      check("fl_req_before", bus.imem_req, 1);
      tick();
      check("fl_valid_in_flush_cycle", bus.ir_valid, 1);
      n0 = issued;
      flush_addr = 8'h40; flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_handshake_counted", issued - n0, 1);
      sb.delete();
      expect_word(8'h40);
      n = 0;
      while (!bus.ir_valid && n < 20) begin tick(); n++; end
      check("fl_next_pc", {bus.ir_valid, bus.pc_out}, {1'b1, 8'h40});
      check("fl_next_word", bus.ir_out, mk(OP_MUL, 8'h40));
      wait_halted("fl_halted");
      check("fl_sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
